// File: rtl/tnoc_vc_link_scheduler_if.sv
// Link-side bundle of the VC scheduler: per-VC requests and credits in, grant and status out.
// The scheduler attaches through the slave modport; the VC source and downstream credit logic use master.
interface tnoc_vc_link_scheduler_if #(
    parameter int CHANNELS = 2
);
    localparam int LVW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] vc_request;
    logic [CHANNELS-1:0] vc_tail;
    logic [CHANNELS-1:0] credit_return;
    logic [CHANNELS-1:0] vc_grant;
    logic [CHANNELS-1:0] credit_available;
    logic                locked;
    logic [LVW-1:0]      locked_vc;
    logic                credit_error;

    modport master (
        output vc_request, vc_tail, credit_return,
        input  vc_grant, credit_available, locked, locked_vc, credit_error
    );

    modport slave (
        input  vc_request, vc_tail, credit_return,
        output vc_grant, credit_available, locked, locked_vc, credit_error
    );
endinterface

// File: rtl/tnoc_vc_link_scheduler.sv
// Credit-based wormhole scheduler for one fabric link, round-robin between packets of CHANNELS VCs.
// Zero-cycle grant from request; a VC with no credit is never granted, so backpressure is credit only.
module tnoc_vc_link_scheduler #(
    parameter int CHANNELS = 2,
    parameter int CREDITS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    tnoc_vc_link_scheduler_if.slave      link
);
    localparam int CREDIT_WIDTH = $clog2(CREDITS + 1);
    localparam int LVW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [LVW-1:0]          ptr_q, ptr_d;
    logic [LVW-1:0]          locked_vc_q, locked_vc_d;
    logic                    credit_error_q, credit_error_d;
    logic [CREDIT_WIDTH-1:0] credit_q [CHANNELS];
    logic [CREDIT_WIDTH-1:0] credit_d [CHANNELS];

    logic [CHANNELS-1:0]     eligible;
    logic [CHANNELS-1:0]     grant;
    logic                    grant_vld;
    logic [LVW-1:0]          grant_idx;
    logic [LVW-1:0]          search_idx;
    int                      idx_int;

    // Arbitration: rotating priority search in IDLE, owner-only in LOCKED.
    always_comb begin
        eligible   = '0;
        grant      = '0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        idx_int    = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = link.vc_request[i] & (credit_q[i] != '0);
        end
        if (!rst) begin
            if (state_q == S_IDLE) begin
                for (int j = 0; j < CHANNELS; j++) begin
                    idx_int = int'(ptr_q) + j;
                    if (idx_int >= CHANNELS) begin
                        idx_int = idx_int - CHANNELS;
                    end
                    search_idx = LVW'(idx_int);
                    if (!grant_vld && eligible[search_idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = search_idx;
                    end
                end
            end else begin
                grant_vld = eligible[locked_vc_q];
                grant_idx = locked_vc_q;
            end
            if (grant_vld) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        locked_vc_d    = locked_vc_q;
        credit_error_d = credit_error_q;
        if (grant_vld) begin
            if (link.vc_tail[grant_idx]) begin
                state_d     = S_IDLE;
                locked_vc_d = '0;
                if (int'(grant_idx) + 1 >= CHANNELS) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = LVW'(int'(grant_idx) + 1);
                end
            end else begin
                state_d     = S_LOCKED;
                locked_vc_d = grant_idx;
            end
        end
        // A simultaneous grant and return cancel out, so that case cannot overflow.
        for (int i = 0; i < CHANNELS; i++) begin
            credit_d[i] = credit_q[i];
            if (grant[i] && !link.credit_return[i]) begin
                credit_d[i] = credit_q[i] - CREDIT_WIDTH'(1);
            end else if (link.credit_return[i] && !grant[i]) begin
                if (credit_q[i] == CREDIT_WIDTH'(CREDITS)) begin
                    credit_error_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CREDIT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            locked_vc_q    <= '0;
            credit_error_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                credit_q[i] <= CREDIT_WIDTH'(CREDITS);
            end
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            locked_vc_q    <= locked_vc_d;
            credit_error_q <= credit_error_d;
            for (int i = 0; i < CHANNELS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    always_comb begin
        link.credit_available = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            link.credit_available[i] = (credit_q[i] != '0);
        end
    end

    assign link.vc_grant     = grant;
    assign link.locked       = (state_q == S_LOCKED);
    assign link.locked_vc    = locked_vc_q;
    assign link.credit_error = credit_error_q;

endmodule

// File: tb/tb_tnoc_vc_link_scheduler.sv
// Directed bench for the VC link scheduler with CHANNELS=2, CREDITS=4.
module tb_tnoc_vc_link_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tnoc_vc_link_scheduler_if #(.CHANNELS(2)) link();

    tnoc_vc_link_scheduler #(.CHANNELS(2), .CREDITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        link.vc_request    = 2'b00;
        link.vc_tail       = 2'b00;
        link.credit_return = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        link.vc_request    = 2'b11;
        link.vc_tail       = 2'b11;
        link.credit_return = 2'b00;
        #1;
        checks++;
        if (link.vc_grant !== 2'b00) begin
            $display("FAIL reset_grant: got %b expected 00", link.vc_grant); errors++;
        end
        tick();
        #1;
        checks++;
        if (link.locked !== 1'b0 || link.locked_vc !== 1'b0 || link.credit_error !== 1'b0) begin
            $display("FAIL reset_status: got locked=%b locked_vc=%b err=%b expected 0/0/0",
                     link.locked, link.locked_vc, link.credit_error); errors++;
        end
        checks++;
        if (link.credit_available !== 2'b11 || dut.credit_q[0] !== 3'd4 || dut.credit_q[1] !== 3'd4) begin
            $display("FAIL reset_credits: got avail=%b c0=%0d c1=%0d expected 11/4/4",
                     link.credit_available, dut.credit_q[0], dut.credit_q[1]); errors++;
        end
        checks++;
        if (link.vc_grant !== 2'b00) begin
            $display("FAIL reset_grant_held: got %b expected 00", link.vc_grant); errors++;
        end
        rst = 1'b0;
        link.vc_request = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        link.vc_request = 2'b11;
        link.vc_tail    = 2'b11;
        for (int c = 0; c < 4; c++) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (link.vc_grant !== exp_g || link.locked !== 1'b0) begin
                $display("FAIL rr_grant[%0d]: got grant=%b locked=%b expected %b/0",
                         c, link.vc_grant, link.locked, exp_g); errors++;
            end
            tick();
        end
        link.vc_request = 2'b00;
        #1;
        checks++;
        if (dut.credit_q[0] !== 3'd2 || dut.credit_q[1] !== 3'd2 || link.locked !== 1'b0) begin
            $display("FAIL rr_credits: got c0=%0d c1=%0d locked=%b expected 2/2/0",
                     dut.credit_q[0], dut.credit_q[1], link.locked); errors++;
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0] tails [3];
        tails[0] = 2'b10;
        tails[1] = 2'b10;
        tails[2] = 2'b11;
        do_reset();
        link.vc_request = 2'b11;
        for (int c = 0; c < 3; c++) begin
            link.vc_tail = tails[c];
            #1;
            checks++;
            if (link.vc_grant !== 2'b01) begin
                $display("FAIL lock_grant[%0d]: got %b expected 01", c, link.vc_grant); errors++;
            end
            if (c > 0) begin
                checks++;
                if (link.locked !== 1'b1 || link.locked_vc !== 1'b0) begin
                    $display("FAIL lock_state[%0d]: got locked=%b vc=%b expected 1/0",
                             c, link.locked, link.locked_vc); errors++;
                end
            end
            tick();
        end
        link.vc_tail = 2'b11;
        #1;
        checks++;
        if (link.vc_grant !== 2'b10 || link.locked !== 1'b0) begin
            $display("FAIL lock_release: got grant=%b locked=%b expected 10/0",
                     link.vc_grant, link.locked); errors++;
        end
        tick();
        link.vc_request = 2'b00;
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        link.vc_request = 2'b01;
        link.vc_tail    = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (link.vc_grant !== 2'b01) begin
                $display("FAIL exhaust_grant[%0d]: got %b expected 01", c, link.vc_grant); errors++;
            end
            tick();
        end
        tick();
        #1;
        checks++;
        if (link.vc_grant !== 2'b00 || link.credit_available !== 2'b10) begin
            $display("FAIL exhaust_stall: got grant=%b avail=%b expected 00/10",
                     link.vc_grant, link.credit_available); errors++;
        end
        link.credit_return = 2'b01;
        #1;
        checks++;
        if (link.vc_grant !== 2'b00) begin
            $display("FAIL exhaust_return_cycle: got %b expected 00", link.vc_grant); errors++;
        end
        tick();
        link.credit_return = 2'b00;
        #1;
        checks++;
        if (link.vc_grant !== 2'b01) begin
            $display("FAIL exhaust_one_more: got %b expected 01", link.vc_grant); errors++;
        end
        tick();
        #1;
        checks++;
        if (link.vc_grant !== 2'b00 || link.credit_available !== 2'b10) begin
            $display("FAIL exhaust_after: got grant=%b avail=%b expected 00/10",
                     link.vc_grant, link.credit_available); errors++;
        end
        link.vc_request = 2'b00;
    endtask

    task automatic test_same_cycle_return();
        do_reset();
        link.vc_request = 2'b10;
        link.vc_tail    = 2'b10;
        for (int c = 0; c < 3; c++) tick();
        #1;
        checks++;
        if (dut.credit_q[1] !== 3'd1) begin
            $display("FAIL same_setup: got c1=%0d expected 1", dut.credit_q[1]); errors++;
        end
        link.credit_return = 2'b10;
        #1;
        checks++;
        if (link.vc_grant !== 2'b10) begin
            $display("FAIL same_grant: got %b expected 10", link.vc_grant); errors++;
        end
        tick();
        link.credit_return = 2'b00;
        #1;
        checks++;
        if (dut.credit_q[1] !== 3'd1 || link.credit_available[1] !== 1'b1) begin
            $display("FAIL same_counter: got c1=%0d avail1=%b expected 1/1",
                     dut.credit_q[1], link.credit_available[1]); errors++;
        end
        checks++;
        if (link.vc_grant !== 2'b10) begin
            $display("FAIL same_next_flit: got %b expected 10", link.vc_grant); errors++;
        end
        tick();
        link.vc_request = 2'b00;
    endtask

    task automatic test_overflow();
        do_reset();
        link.credit_return = 2'b01;
        #1;
        checks++;
        if (link.credit_error !== 1'b0) begin
            $display("FAIL ovf_before: got %b expected 0", link.credit_error); errors++;
        end
        tick();
        link.credit_return = 2'b00;
        #1;
        checks++;
        if (link.credit_error !== 1'b1 || dut.credit_q[0] !== 3'd4) begin
            $display("FAIL ovf_set: got err=%b c0=%0d expected 1/4",
                     link.credit_error, dut.credit_q[0]); errors++;
        end
        tick();
        tick();
        checks++;
        if (link.credit_error !== 1'b1) begin
            $display("FAIL ovf_sticky: got %b expected 1", link.credit_error); errors++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (link.credit_error !== 1'b0) begin
            $display("FAIL ovf_clear: got %b expected 0", link.credit_error); errors++;
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        link.vc_request = 2'b10;
        link.vc_tail    = 2'b00;
        for (int c = 0; c < 3; c++) tick();
        #1;
        checks++;
        if (link.locked !== 1'b1 || link.locked_vc !== 1'b1 || dut.credit_q[1] !== 3'd1) begin
            $display("FAIL mid_setup: got locked=%b vc=%b c1=%0d expected 1/1/1",
                     link.locked, link.locked_vc, dut.credit_q[1]); errors++;
        end
        rst = 1'b1;
        link.vc_request = 2'b11;
        #1;
        checks++;
        if (link.vc_grant !== 2'b00) begin
            $display("FAIL mid_grant_in_rst: got %b expected 00", link.vc_grant); errors++;
        end
        tick();
        #1;
        checks++;
        if (link.locked !== 1'b0 || dut.credit_q[0] !== 3'd4 || dut.credit_q[1] !== 3'd4
            || link.vc_grant !== 2'b00) begin
            $display("FAIL mid_after_rst: got locked=%b c0=%0d c1=%0d grant=%b expected 0/4/4/00",
                     link.locked, dut.credit_q[0], dut.credit_q[1], link.vc_grant); errors++;
        end
        rst = 1'b0;
        link.vc_tail = 2'b11;
        #1;
        checks++;
        if (link.vc_grant !== 2'b01) begin
            $display("FAIL mid_first_grant: got %b expected 01", link.vc_grant); errors++;
        end
        tick();
        link.vc_request = 2'b00;
    endtask

    initial begin
        link.vc_request    = 2'b00;
        link.vc_tail       = 2'b00;
        link.credit_return = 2'b00;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_credit_exhaustion();
        test_same_cycle_return();
        test_overflow();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
